// File: rtl/dma_rd_desc_arbiter_pkg.sv
// Shared definitions for the DMA read-descriptor arbiter: owner encoding,
// completion error width and the issue FSM state type.
package dma_rd_desc_arbiter_pkg;
  localparam logic OWNER_CU     = 1'b0;
  localparam logic OWNER_RE     = 1'b1;
  localparam int   STATUS_ERR_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_t;
endpackage

// File: rtl/dma_rd_desc_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. The pointer names the owner preferred on a
// tie and moves to the other owner each time an issue completes.
module rr_arb2
  import dma_rd_desc_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_last_owner,
  output logic       o_gnt_valid,
  output logic       o_gnt_owner
);
  logic r_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= OWNER_CU;
    end else if (i_update) begin
      r_ptr <= ~i_last_owner;
    end
  end

  always_comb begin
    o_gnt_valid = |i_req;
    o_gnt_owner = OWNER_CU;
    if (i_req[0] && i_req[1]) begin
      o_gnt_owner = r_ptr;
    end else if (i_req[1]) begin
      o_gnt_owner = OWNER_RE;
    end
  end
endmodule

// File: rtl/dma_rd_desc_arbiter.sv
// Shares one DMA read-descriptor channel between CU and RE with round-robin
// grant, owner-encoded tags, outstanding-read caps and status routing.
module dma_rd_desc_arbiter
  import dma_rd_desc_arbiter_pkg::*;
#(
  parameter int DMA_ADDR_WIDTH    = 64,
  parameter int RAM_ADDR_WIDTH    = 15,
  parameter int LEN_WIDTH         = 16,
  parameter int TAG_WIDTH         = 8,
  parameter int MAX_OUTSTANDING   = 16,
  parameter int TOTAL_OUTSTANDING = 32
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [DMA_ADDR_WIDTH-1:0]              s_axis_cu_desc_dma_addr,
  input  logic [RAM_ADDR_WIDTH-1:0]              s_axis_cu_desc_ram_addr,
  input  logic [LEN_WIDTH-1:0]                   s_axis_cu_desc_len,
  input  logic                                   s_axis_cu_desc_valid,
  output logic                                   s_axis_cu_desc_ready,
  input  logic [DMA_ADDR_WIDTH-1:0]              s_axis_re_desc_dma_addr,
  input  logic [RAM_ADDR_WIDTH-1:0]              s_axis_re_desc_ram_addr,
  input  logic [LEN_WIDTH-1:0]                   s_axis_re_desc_len,
  input  logic                                   s_axis_re_desc_valid,
  output logic                                   s_axis_re_desc_ready,
  output logic [DMA_ADDR_WIDTH-1:0]              m_axis_dma_read_desc_dma_addr,
  output logic [RAM_ADDR_WIDTH-1:0]              m_axis_dma_read_desc_ram_addr,
  output logic [LEN_WIDTH-1:0]                   m_axis_dma_read_desc_len,
  output logic [TAG_WIDTH-1:0]                   m_axis_dma_read_desc_tag,
  output logic                                   m_axis_dma_read_desc_valid,
  input  logic                                   m_axis_dma_read_desc_ready,
  output logic                                   m_axis_dma_read_wqe_tag,
  output logic                                   m_axis_dma_read_wqe_valid,
  output logic                                   m_axis_dma_read_wqe_ready,
  input  logic [TAG_WIDTH-1:0]                   s_axis_dma_read_desc_status_tag,
  input  logic [STATUS_ERR_W-1:0]                s_axis_dma_read_desc_status_error,
  input  logic                                   s_axis_dma_read_desc_status_valid,
  output logic [TAG_WIDTH-2:0]                   m_axis_cu_status_tag,
  output logic [STATUS_ERR_W-1:0]                m_axis_cu_status_error,
  output logic                                   m_axis_cu_status_valid,
  output logic [TAG_WIDTH-2:0]                   m_axis_re_status_tag,
  output logic [STATUS_ERR_W-1:0]                m_axis_re_status_error,
  output logic                                   m_axis_re_status_valid,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   cu_outstanding,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   re_outstanding
);
  localparam int SEQ_W  = TAG_WIDTH - 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int TOT_W  = ($clog2(TOTAL_OUTSTANDING + 1) > CNT_W + 1) ?
                          $clog2(TOTAL_OUTSTANDING + 1) : CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_OUTSTANDING);
  localparam logic [TOT_W-1:0] TOT_CAP = TOT_W'(TOTAL_OUTSTANDING);

  arb_state_t r_state, w_state_next;
  logic                      w_grant, w_issue_done, w_gnt_valid, w_gnt_owner;
  logic [1:0]                w_req_valid, w_elig, w_inc, w_dec, w_underflow;
  logic [DMA_ADDR_WIDTH-1:0] w_req_dma_addr [2];
  logic [RAM_ADDR_WIDTH-1:0] w_req_ram_addr [2];
  logic [LEN_WIDTH-1:0]      w_req_len      [2];
  logic [CNT_W-1:0]          r_cnt [2];
  logic [SEQ_W-1:0]          r_seq [2];
  logic [TOT_W-1:0]          w_total;
  logic [DMA_ADDR_WIDTH-1:0] r_dma_addr;
  logic [RAM_ADDR_WIDTH-1:0] r_ram_addr;
  logic [LEN_WIDTH-1:0]      r_len;
  logic [TAG_WIDTH-1:0]      r_tag;
  logic                      r_owner;
  logic                      r_cu_status_valid, r_re_status_valid, r_underflow_seen;
  logic [SEQ_W-1:0]          r_status_seq;
  logic [STATUS_ERR_W-1:0]   r_status_error;

  assign w_req_valid                = {s_axis_re_desc_valid, s_axis_cu_desc_valid};
  assign w_req_dma_addr[OWNER_CU]   = s_axis_cu_desc_dma_addr;
  assign w_req_dma_addr[OWNER_RE]   = s_axis_re_desc_dma_addr;
  assign w_req_ram_addr[OWNER_CU]   = s_axis_cu_desc_ram_addr;
  assign w_req_ram_addr[OWNER_RE]   = s_axis_re_desc_ram_addr;
  assign w_req_len[OWNER_CU]        = s_axis_cu_desc_len;
  assign w_req_len[OWNER_RE]        = s_axis_re_desc_len;
  assign w_total = TOT_W'(r_cnt[0]) + TOT_W'(r_cnt[1]);

  // Issue and completion on the same owner in one cycle cancel out.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_owner
      assign w_elig[gi] = w_req_valid[gi] && (r_cnt[gi] < CNT_CAP) && (w_total < TOT_CAP);
      assign w_inc[gi]  = w_issue_done && (r_owner == 1'(gi));
      assign w_dec[gi]  = s_axis_dma_read_desc_status_valid &&
                          (s_axis_dma_read_desc_status_tag[TAG_WIDTH-1] == 1'(gi));
      assign w_underflow[gi] = w_dec[gi] && !w_inc[gi] && (r_cnt[gi] == '0);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_cnt[gi] <= '0;
          r_seq[gi] <= '0;
        end else begin
          if (w_inc[gi] && !w_dec[gi]) begin
            r_cnt[gi] <= r_cnt[gi] + 1'b1;
          end else if (w_dec[gi] && !w_inc[gi] && (r_cnt[gi] != '0)) begin
            r_cnt[gi] <= r_cnt[gi] - 1'b1;
          end
          if (w_inc[gi]) begin
            r_seq[gi] <= r_seq[gi] + 1'b1;
          end
        end
      end
    end
  endgenerate

  rr_arb2 u_rr_arb2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (w_elig),
    .i_update     (w_issue_done),
    .i_last_owner (r_owner),
    .o_gnt_valid  (w_gnt_valid),
    .o_gnt_owner  (w_gnt_owner)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_issue_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rst_n && w_gnt_valid) begin
          w_grant      = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_axis_dma_read_desc_ready) begin
          w_issue_done = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dma_addr <= '0;
      r_ram_addr <= '0;
      r_len      <= '0;
      r_tag      <= '0;
      r_owner    <= OWNER_CU;
    end else if (w_grant) begin
      r_dma_addr <= w_req_dma_addr[w_gnt_owner];
      r_ram_addr <= w_req_ram_addr[w_gnt_owner];
      r_len      <= w_req_len[w_gnt_owner];
      r_tag      <= {w_gnt_owner, r_seq[w_gnt_owner]};
      r_owner    <= w_gnt_owner;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cu_status_valid <= 1'b0;
      r_re_status_valid <= 1'b0;
      r_status_seq      <= '0;
      r_status_error    <= '0;
      r_underflow_seen  <= 1'b0;
    end else begin
      r_cu_status_valid <= w_dec[OWNER_CU];
      r_re_status_valid <= w_dec[OWNER_RE];
      if (s_axis_dma_read_desc_status_valid) begin
        r_status_seq   <= s_axis_dma_read_desc_status_tag[SEQ_W-1:0];
        r_status_error <= s_axis_dma_read_desc_status_error;
      end
      r_underflow_seen <= r_underflow_seen || (|w_underflow);
    end
  end

  // A completion for an owner with nothing in flight is an upstream protocol error.
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !r_underflow_seen);

  assign s_axis_cu_desc_ready          = w_grant && (w_gnt_owner == OWNER_CU);
  assign s_axis_re_desc_ready          = w_grant && (w_gnt_owner == OWNER_RE);
  assign m_axis_dma_read_desc_dma_addr = r_dma_addr;
  assign m_axis_dma_read_desc_ram_addr = r_ram_addr;
  assign m_axis_dma_read_desc_len      = r_len;
  assign m_axis_dma_read_desc_tag      = r_tag;
  assign m_axis_dma_read_desc_valid    = (r_state == ST_ISSUE);
  assign m_axis_dma_read_wqe_tag       = r_owner;
  assign m_axis_dma_read_wqe_valid     = (r_state == ST_ISSUE);
  assign m_axis_dma_read_wqe_ready     = m_axis_dma_read_desc_ready;
  assign m_axis_cu_status_tag          = r_status_seq;
  assign m_axis_cu_status_error        = r_status_error;
  assign m_axis_cu_status_valid        = r_cu_status_valid;
  assign m_axis_re_status_tag          = r_status_seq;
  assign m_axis_re_status_error        = r_status_error;
  assign m_axis_re_status_valid        = r_re_status_valid;
  assign cu_outstanding                = r_cnt[OWNER_CU];
  assign re_outstanding                = r_cnt[OWNER_RE];
endmodule
